pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core: PC, IF, ID, EX, MEM, WB.
- Merges stage stall requests into one per-stage stall vector.
- Schedules flushes with a redirect PC.
- Provides debug halt/single-step by draining the back end of the pipe.
- Keeps a saturating stall-cycle performance counter.

Parameters:
CNT_W, 16, width of stall_cycles counter
DRAIN_CYC, 3, number of un-stalled EX-advance cycles needed to drain EX/MEM/WB before halted asserts

Ports:
clk  in  1  clock
rst  in  1  reset; reset rst, synchronous, active-high
stallreq_id  in  1  ID stage requests stall (operand hazard)
stallreq_ex  in  1  EX stage requests stall (multi-cycle op)
stallreq_mem  in  1  MEM stage requests stall (bus wait)
flush_req  in  1  one-cycle request to flush pipeline and redirect
flush_pc  in  32  redirect target, valid with flush_req
halt_req  in  1  level; debug halt request
step_req  in  1  one-cycle pulse; execute one issue slot while halted
clr_cnt  in  1  synchronous clear of stall_cycles
stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold stage
flush  out  1  registered; clear all pipeline registers this cycle
new_pc  out  32  registered; redirect PC, valid while flush=1
halted  out  1  registered; pipe drained and frozen
stall_cycles  out  CNT_W  saturating count of cycles with stall[0]=1

Behaviour:
- Reset values (rst high at a clock edge):
  - state=RUN, flush=0, new_pc=0, halted=0, stall_cycles=0, drain counter=0, pending flush cleared.
  - stall is combinational and forced to 6'b000000 while rst=1.
- Request vector req_vec, combinational, priority mem > ex > id:
  - stallreq_mem: 6'b011111
  - else stallreq_ex: 6'b001111
  - else stallreq_id: 6'b000111
  - else: 6'b000000
- Halt vector: 6'b000111 in DRAIN and HALT, else 0.
- stall = req_vec | halt vector. Exception: in FLUSH and STEP, stall = req_vec only.
- States: RUN, DRAIN, HALT, STEP, FLUSH.
- Flush scheduling:
  - flush_req captures flush_pc into a pending register, pend=1.
  - Pending flush is taken at the first edge where stallreq_mem=0. State then goes to FLUSH.
  - In FLUSH, flush=1 and new_pc=pending PC for exactly one cycle; pend clears.
  - Latency with no mem stall: flush_req in cycle N gives flush=1 in cycle N+1.
  - A flush_req arriving while pend=1 or in FLUSH overwrites the pending PC (latest wins). If it arrives in FLUSH, another FLUSH follows.
  - Flush has priority over all other transitions from any state. After FLUSH, state is RUN, halted=0, drain counter=0.
- RUN:
  - halt_req=1 and no pending flush: go to DRAIN, drain counter loaded with DRAIN_CYC.
- DRAIN:
  - Counter decrements only on cycles with stall[3]=0.
  - When the counter reaches 0, go to HALT; halted=1 from the next cycle.
  - halt_req=0 in DRAIN: return to RUN, no halted pulse.
- HALT:
  - halted=1.
  - step_req: go to STEP.
  - halt_req=0: go to RUN; halted=0 next cycle.
- STEP:
  - One cycle with the halt vector removed; halted=0 during STEP.
  - Then back to DRAIN with counter reloaded with DRAIN_CYC; re-halts after the drain.
  - step_req while not in HALT is ignored.
- stall_cycles:
  - Increments each cycle stall[0]=1, saturating at all-ones.
  - clr_cnt has priority over increment.
  - Not affected by flush.
- rst mid-flush or mid-drain abandons the operation; nothing is retained.

Test Plan:
- Priority: stallreq_id=1 and stallreq_ex=1 together -> stall=6'b001111. Add stallreq_mem=1 -> 6'b011111. All low -> 6'b000000 in the same cycle.
- Flush: flush_req=1, flush_pc=32'h0000_0100 at cycle 10 -> flush=1, new_pc=32'h100 at cycle 11 only. Flush_req during stallreq_mem high for 4 cycles -> flush delayed until the cycle after mem stall drops.
- Halt: halt_req=1 from cycle 5, no stall requests -> stall=6'b000111 from cycle 6; halted=1 at cycle 9 (DRAIN_CYC=3). With stallreq_ex high for 2 of those cycles, halted=1 at cycle 11.
- Step: in HALT, pulse step_req -> one cycle stall=6'b000000 and halted=0, then 3 drain cycles, then halted=1 again. halt_req drop -> RUN, stall=0.
- Flush in HALT: flush_req with flush_pc=32'hBFC0_0000 -> flush=1, new_pc=32'hBFC00000, halted=0. With halt_req still high, DRAIN re-entered next cycle.
- Counter: CNT_W=4, hold stallreq_id 20 cycles -> stall_cycles saturates at 15. clr_cnt -> 0 next cycle. rst mid-DRAIN -> RUN, all outputs 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stage stall requests, schedules
// redirect flushes, sequences debug halt/single-step and counts stall cycles.
module pipe_ctrl #(
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id_i,
  input  logic             stallreq_ex_i,
  input  logic             stallreq_mem_i,
  input  logic             flush_req_i,
  input  logic [31:0]      flush_pc_i,
  input  logic             halt_req_i,
  input  logic             step_req_i,
  input  logic             clr_cnt_i,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic [31:0]      new_pc_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_DRAIN = 3'd1,
    S_HALT  = 3'd2,
    S_STEP  = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  state_t           state_q;
  logic [7:0]       drain_q;
  logic             pend_q;
  logic [31:0]      pend_pc_q;
  logic             flush_q;
  logic [31:0]      new_pc_q;
  logic             halted_q;
  logic [CNT_W-1:0] cnt_q;

  logic [5:0]  req_vec_s;
  logic [5:0]  halt_vec_s;
  logic        take_flush_s;
  logic [31:0] flush_tgt_s;

  // Deepest requesting stage wins: it must hold itself and everything upstream.
  always_comb begin
    req_vec_s = 6'b000000;
    if (stallreq_mem_i) begin
      req_vec_s = 6'b011111;
    end else if (stallreq_ex_i) begin
      req_vec_s = 6'b001111;
    end else if (stallreq_id_i) begin
      req_vec_s = 6'b000111;
    end else begin
      req_vec_s = 6'b000000;
    end
  end

  assign halt_vec_s   = (state_q == S_DRAIN || state_q == S_HALT) ? 6'b000111 : 6'b000000;
  assign stall_o      = rst ? 6'b000000 : (req_vec_s | halt_vec_s);
  // A request arriving this cycle is taken directly when MEM is not stalled.
  assign take_flush_s = (pend_q | flush_req_i) & ~stallreq_mem_i;
  assign flush_tgt_s  = flush_req_i ? flush_pc_i : pend_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RUN;
      drain_q   <= 8'd0;
      pend_q    <= 1'b0;
      pend_pc_q <= 32'd0;
      flush_q   <= 1'b0;
      new_pc_q  <= 32'd0;
      halted_q  <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      flush_q  <= 1'b0;
      halted_q <= 1'b0;

      if (clr_cnt_i) begin
        cnt_q <= {CNT_W{1'b0}};
      end else if (stall_o[0] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      if (take_flush_s) begin
        state_q  <= S_FLUSH;
        flush_q  <= 1'b1;
        new_pc_q <= flush_tgt_s;
        pend_q   <= 1'b0;
        drain_q  <= 8'd0;
      end else begin
        if (flush_req_i) begin
          pend_q    <= 1'b1;
          pend_pc_q <= flush_pc_i;
        end
        case (state_q)
          S_RUN: begin
            if (halt_req_i && !pend_q && !flush_req_i) begin
              state_q <= S_DRAIN;
              drain_q <= 8'(DRAIN_CYC);
            end
          end
          S_DRAIN: begin
            if (!halt_req_i) begin
              state_q <= S_RUN;
              drain_q <= 8'd0;
            end else if (!stall_o[3]) begin
              // EX advanced this cycle; the last one completes the drain.
              if (drain_q <= 8'd1) begin
                state_q  <= S_HALT;
                halted_q <= 1'b1;
                drain_q  <= 8'd0;
              end else begin
                drain_q <= drain_q - 8'd1;
              end
            end
          end
          S_HALT: begin
            if (!halt_req_i) begin
              state_q <= S_RUN;
            end else if (step_req_i) begin
              state_q <= S_STEP;
            end else begin
              halted_q <= 1'b1;
            end
          end
          S_STEP: begin
            state_q <= S_DRAIN;
            drain_q <= 8'(DRAIN_CYC);
          end
          S_FLUSH: begin
            state_q <= S_RUN;
            drain_q <= 8'd0;
          end
          default: begin
            state_q <= S_RUN;
            drain_q <= 8'd0;
          end
        endcase
      end
    end
  end

  assign flush_o        = flush_q;
  assign new_pc_o       = new_pc_q;
  assign halted_o       = halted_q;
  assign stall_cycles_o = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (CNT_W=4 to reach saturation quickly).
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic        halt_req, step_req, clr_cnt;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        halted;
  logic [3:0]  stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  pipe_ctrl #(.CNT_W(4), .DRAIN_CYC(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id_i  (stallreq_id),
    .stallreq_ex_i  (stallreq_ex),
    .stallreq_mem_i (stallreq_mem),
    .flush_req_i    (flush_req),
    .flush_pc_i     (flush_pc),
    .halt_req_i     (halt_req),
    .step_req_i     (step_req),
    .clr_cnt_i      (clr_cnt),
    .stall_o        (stall),
    .flush_o        (flush),
    .new_pc_o       (new_pc),
    .halted_o       (halted),
    .stall_cycles_o (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b1;
    flush_req = 1'b0; flush_pc = 32'd0; halt_req = 1'b0; step_req = 1'b0; clr_cnt = 1'b0;
    tick(2);
    check("rst_stall_forced", {26'd0, stall}, 32'd0);
    stallreq_mem = 1'b0;
    rst = 1'b0;
    #1;
    check("reset_flush", {31'd0, flush}, 32'd0);
    check("reset_new_pc", new_pc, 32'd0);
    check("reset_halted", {31'd0, halted}, 32'd0);
    check("reset_cnt", {28'd0, stall_cycles}, 32'd0);
    check("reset_stall", {26'd0, stall}, 32'd0);

    // Priority merge (combinational)
    stallreq_id = 1'b1; stallreq_ex = 1'b1; #1;
    check("prio_id_ex", {26'd0, stall}, 32'h0000_000F);
    stallreq_mem = 1'b1; #1;
    check("prio_mem", {26'd0, stall}, 32'h0000_001F);
    stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0; #1;
    check("prio_none", {26'd0, stall}, 32'd0);
    stallreq_id = 1'b1; #1;
    check("prio_id", {26'd0, stall}, 32'h0000_0007);
    stallreq_id = 1'b0;

    // Plain flush: one-cycle latency, single cycle wide
    flush_req = 1'b1; flush_pc = 32'h0000_0100;
    tick(1);
    flush_req = 1'b0;
    check("flush_asserted", {31'd0, flush}, 32'd1);
    check("flush_pc", new_pc, 32'h0000_0100);
    tick(1);
    check("flush_one_cycle", {31'd0, flush}, 32'd0);

    // Flush deferred behind 4 cycles of MEM stall
    stallreq_mem = 1'b1; flush_req = 1'b1; flush_pc = 32'h0000_0200;
    tick(1);
    flush_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("flush_held_by_mem", {31'd0, flush}, 32'd0);
      tick(1);
    end
    check("flush_held_by_mem", {31'd0, flush}, 32'd0);
    stallreq_mem = 1'b0;
    tick(1);
    check("flush_after_mem", {31'd0, flush}, 32'd1);
    check("flush_after_mem_pc", new_pc, 32'h0000_0200);
    tick(1);
    check("flush_after_mem_end", {31'd0, flush}, 32'd0);

    // Latest pending PC wins
    stallreq_mem = 1'b1; flush_req = 1'b1; flush_pc = 32'h0000_0300;
    tick(1);
    flush_pc = 32'h0000_0304;
    tick(1);
    flush_req = 1'b0; stallreq_mem = 1'b0;
    tick(1);
    check("flush_latest", {31'd0, flush}, 32'd1);
    check("flush_latest_pc", new_pc, 32'h0000_0304);
    tick(1);

    // Halt with no stalls: halted after 3 drain cycles
    halt_req = 1'b1;
    tick(1);
    check("drain_stall", {26'd0, stall}, 32'h0000_0007);
    check("drain_halted0", {31'd0, halted}, 32'd0);
    tick(2);
    check("drain_not_yet", {31'd0, halted}, 32'd0);
    tick(1);
    check("halted", {31'd0, halted}, 32'd1);
    check("halt_stall", {26'd0, stall}, 32'h0000_0007);

    // Single step: one free cycle, then re-drain
    step_req = 1'b1;
    tick(1);
    step_req = 1'b0;
    check("step_stall", {26'd0, stall}, 32'd0);
    check("step_halted", {31'd0, halted}, 32'd0);
    tick(1);
    check("step_redrain_stall", {26'd0, stall}, 32'h0000_0007);
    tick(2);
    check("step_redrain_halted0", {31'd0, halted}, 32'd0);
    tick(1);
    check("step_rehalted", {31'd0, halted}, 32'd1);

    // Flush while halted
    flush_req = 1'b1; flush_pc = 32'hBFC0_0000;
    tick(1);
    flush_req = 1'b0;
    check("halt_flush", {31'd0, flush}, 32'd1);
    check("halt_flush_pc", new_pc, 32'hBFC0_0000);
    check("halt_flush_halted", {31'd0, halted}, 32'd0);
    check("halt_flush_stall", {26'd0, stall}, 32'd0);
    tick(2);
    check("halt_flush_redrain", {26'd0, stall}, 32'h0000_0007);
    halt_req = 1'b0;
    tick(1);
    check("drain_abort_stall", {26'd0, stall}, 32'd0);
    check("drain_abort_halted", {31'd0, halted}, 32'd0);

    // Halt with EX stalled for two drain cycles
    halt_req = 1'b1;
    tick(1);
    stallreq_ex = 1'b1;
    tick(2);
    stallreq_ex = 1'b0;
    tick(2);
    check("ex_drain_not_yet", {31'd0, halted}, 32'd0);
    tick(1);
    check("ex_drain_halted", {31'd0, halted}, 32'd1);
    halt_req = 1'b0;
    tick(1);
    check("unhalt_halted", {31'd0, halted}, 32'd0);
    check("unhalt_stall", {26'd0, stall}, 32'd0);

    // Saturating counter
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    check("cnt_clear", {28'd0, stall_cycles}, 32'd0);
    stallreq_id = 1'b1;
    tick(5);
    check("cnt_5", {28'd0, stall_cycles}, 32'd5);
    tick(15);
    check("cnt_sat", {28'd0, stall_cycles}, 32'd15);
    stallreq_id = 1'b0;
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    check("cnt_clr_after_sat", {28'd0, stall_cycles}, 32'd0);

    // Reset mid-drain with a pending flush abandons everything
    halt_req = 1'b1;
    tick(2);
    stallreq_mem = 1'b1; flush_req = 1'b1; flush_pc = 32'h0000_0ABC;
    tick(1);
    flush_req = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_stall", {26'd0, stall}, 32'd0);
    tick(1);
    rst = 1'b0; halt_req = 1'b0; stallreq_mem = 1'b0;
    tick(1);
    check("rst_mid_flush", {31'd0, flush}, 32'd0);
    check("rst_mid_new_pc", new_pc, 32'd0);
    check("rst_mid_halted", {31'd0, halted}, 32'd0);
    check("rst_mid_stall_after", {26'd0, stall}, 32'd0);
    check("rst_mid_cnt", {28'd0, stall_cycles}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
